graph_memory_arb: RTL and testbench

- Multi-requester front end for the graph CSR store: row-index (pointer) memory plus edge-data memory, shared by NUM_PROCS processing elements.
- Per-cycle round-robin arbitration of processor requests onto three physical read lanes: one ptr-memory port and two data-memory ports (A/B).
- Every request carries its processor ID through a fixed-latency tag pipeline, so responses return tagged.
- Sits between the processor array and the BRAMs. Replaces per-processor address muxing and the hand-counted valid delays.

---
 rtl/graph_memory_arb.sv | 159 +++++++++++++++
 tb/tb_graph_memory_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_memory_arb.sv
// rtl/graph_memory_arb.sv - round-robin arbiter and tagged fixed-latency read lanes for the CSR ptr/data BRAMs
module graph_memory_arb #(
    parameter int    NUM_PROCS   = 4,
    parameter int    PROC_BITS   = 2,
    parameter int    DATA_DEPTH  = 16384,
    parameter int    IDX_DEPTH   = 4096,
    parameter int    RAM_LATENCY = 2,
    parameter string DATA_INIT   = "out_addrs.mem",
    parameter string IDX_INIT    = "out_vidx.mem"
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_PROCS-1:0]   req_valid,
    input  logic [NUM_PROCS-1:0]   req_kind,
    input  logic [32*NUM_PROCS-1:0] req_addr,
    output logic [NUM_PROCS-1:0]   req_ready,
    output logic [31:0]            rowidx_out,
    output logic                   rowidx_valid_out,
    output logic [PROC_BITS-1:0]   rowidx_proc_out,
    output logic [31:0]            data_outa,
    output logic                   data_valid_outa,
    output logic [PROC_BITS-1:0]   data_proc_outa,
    output logic [31:0]            data_outb,
    output logic                   data_valid_outb,
    output logic [PROC_BITS-1:0]   data_proc_outb,
    output logic                   addr_err
);
    localparam int DA = $clog2(DATA_DEPTH);
    localparam int IA = $clog2(IDX_DEPTH);

    typedef struct packed {
        logic                 v;
        logic [PROC_BITS-1:0] p;
        logic                 o;
    } tag_t;

    // Read-only BRAM contents; loaded from DATA_INIT / IDX_INIT by the platform flow.
    logic [31:0] idx_mem  [IDX_DEPTH];
    logic [31:0] data_mem [DATA_DEPTH];

    logic [31:0] addr_arr [NUM_PROCS];
    for (genvar g = 0; g < NUM_PROCS; g++) begin : g_addr
        assign addr_arr[g] = req_addr[32*g +: 32];
    end

    logic [PROC_BITS-1:0] idx_rr, data_rr;
    logic [PROC_BITS-1:0] idx_win, a_win, b_win;
    logic                 idx_hit, a_hit, b_hit;

    function automatic logic [PROC_BITS-1:0] wrap_add(input logic [PROC_BITS-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PROCS) s = s - NUM_PROCS;
        return s[PROC_BITS-1:0];
    endfunction

    function automatic logic [PROC_BITS-1:0] next_ptr(input logic [PROC_BITS-1:0] w);
        return (int'(w) == NUM_PROCS - 1) ? '0 : w + 1'b1;
    endfunction

    // One scan per pointer; the data scan hands its first hit to lane A and the second to lane B.
    always_comb begin
        logic [PROC_BITS-1:0] p;
        p       = '0;
        idx_hit = 1'b0;
        a_hit   = 1'b0;
        b_hit   = 1'b0;
        idx_win = '0;
        a_win   = '0;
        b_win   = '0;
        for (int k = 0; k < NUM_PROCS; k++) begin
            p = wrap_add(idx_rr, k);
            if (!idx_hit && req_valid[p] && !req_kind[p]) begin
                idx_hit = 1'b1;
                idx_win = p;
            end
            p = wrap_add(data_rr, k);
            if (req_valid[p] && req_kind[p]) begin
                if (!a_hit) begin
                    a_hit = 1'b1;
                    a_win = p;
                end else if (!b_hit) begin
                    b_hit = 1'b1;
                    b_win = p;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst_in) begin
            if (idx_hit) req_ready[idx_win] = 1'b1;
            if (a_hit)   req_ready[a_win]   = 1'b1;
            if (b_hit)   req_ready[b_win]   = 1'b1;
        end
    end

    logic [31:0] addr_i, addr_a, addr_b;
    assign addr_i = addr_arr[idx_win];
    assign addr_a = addr_arr[a_win];
    assign addr_b = addr_arr[b_win];

    tag_t tag_in [3];
    always_comb begin
        tag_in[0] = '{v: idx_hit && !rst_in, p: idx_win, o: addr_i >= 32'(IDX_DEPTH)};
        tag_in[1] = '{v: a_hit && !rst_in,   p: a_win,   o: addr_a >= 32'(DATA_DEPTH)};
        tag_in[2] = '{v: b_hit && !rst_in,   p: b_win,   o: addr_b >= 32'(DATA_DEPTH)};
    end

    tag_t        tag_pipe [3][RAM_LATENCY];
    logic [31:0] rd_pipe  [3][RAM_LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_rr   <= '0;
            data_rr  <= '0;
            addr_err <= 1'b0;
            for (int l = 0; l < 3; l++)
                for (int i = 0; i < RAM_LATENCY; i++)
                    tag_pipe[l][i] <= '0;
        end else begin
            if (idx_hit) idx_rr <= next_ptr(idx_win);
            if (b_hit)      data_rr <= next_ptr(b_win);
            else if (a_hit) data_rr <= next_ptr(a_win);
            for (int l = 0; l < 3; l++) begin
                tag_pipe[l][0] <= tag_in[l];
                for (int i = 1; i < RAM_LATENCY; i++)
                    tag_pipe[l][i] <= tag_pipe[l][i-1];
                if (tag_in[l].v && tag_in[l].o) addr_err <= 1'b1;
            end
        end
    end

    // BRAM read path: unreset, mirrors the primitive's internal and output registers.
    always_ff @(posedge clk_in) begin
        rd_pipe[0][0] <= idx_mem[addr_i[IA-1:0]];
        rd_pipe[1][0] <= data_mem[addr_a[DA-1:0]];
        rd_pipe[2][0] <= data_mem[addr_b[DA-1:0]];
        for (int l = 0; l < 3; l++)
            for (int i = 1; i < RAM_LATENCY; i++)
                rd_pipe[l][i] <= rd_pipe[l][i-1];
    end

    tag_t t_i, t_a, t_b;
    assign t_i = tag_pipe[0][RAM_LATENCY-1];
    assign t_a = tag_pipe[1][RAM_LATENCY-1];
    assign t_b = tag_pipe[2][RAM_LATENCY-1];

    assign rowidx_valid_out = t_i.v;
    assign rowidx_proc_out  = t_i.p;
    assign rowidx_out       = (t_i.v && !t_i.o) ? rd_pipe[0][RAM_LATENCY-1] : '0;
    assign data_valid_outa  = t_a.v;
    assign data_proc_outa   = t_a.p;
    assign data_outa        = (t_a.v && !t_a.o) ? rd_pipe[1][RAM_LATENCY-1] : '0;
    assign data_valid_outb  = t_b.v;
    assign data_proc_outb   = t_b.p;
    assign data_outb        = (t_b.v && !t_b.o) ? rd_pipe[2][RAM_LATENCY-1] : '0;
endmodule

// File: tb/tb_graph_memory_arb.sv
// tb/tb_graph_memory_arb.sv - scoreboard bench for graph_memory_arb with a round-robin reference model
module tb_graph_memory_arb;
    localparam int N   = 4;
    localparam int PB  = 2;
    localparam int DD  = 16384;
    localparam int ID  = 4096;
    localparam int LAT = 2;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_kind = '0;
    logic [32*N-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     rowidx_out, data_outa, data_outb;
    logic            rowidx_valid_out, data_valid_outa, data_valid_outb;
    logic [PB-1:0]   rowidx_proc_out, data_proc_outa, data_proc_outb;
    logic            addr_err;

    graph_memory_arb #(.NUM_PROCS(N), .PROC_BITS(PB), .DATA_DEPTH(DD), .IDX_DEPTH(ID), .RAM_LATENCY(LAT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_kind(req_kind), .req_addr(req_addr), .req_ready(req_ready),
        .rowidx_out(rowidx_out), .rowidx_valid_out(rowidx_valid_out), .rowidx_proc_out(rowidx_proc_out),
        .data_outa(data_outa), .data_valid_outa(data_valid_outa), .data_proc_outa(data_proc_outa),
        .data_outb(data_outb), .data_valid_outb(data_valid_outb), .data_proc_outb(data_proc_outb),
        .addr_err(addr_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          due;
        int          proc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [3][$];
    logic [31:0] idx_m  [ID];
    logic [31:0] data_m [DD];
    int          checks = 0, errors = 0, cyc = 0;
    int          rr_i = 0, rr_d = 0, err_from = -1;
    bit          mon_on = 1'b0;
    bit          pv [N];
    bit          pk [N];
    logic [31:0] pa [N];
    bit          granted [N];
    string       lane_name [3] = '{"rowidx", "data_a", "data_b"};

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int p = 0; p < N; p++) begin
            req_valid[p]          = pv[p];
            req_kind[p]           = pk[p];
            req_addr[32*p +: 32]  = pa[p];
        end
    endtask

    task automatic push_grant(input int lane, input int p, inout logic [N-1:0] rdy);
        bit          oob;
        logic [31:0] d;
        oob = pk[p] ? (pa[p] >= DD) : (pa[p] >= ID);
        d   = oob ? 32'h0 : (pk[p] ? data_m[pa[p]] : idx_m[pa[p]]);
        rdy[p]     = 1'b1;
        granted[p] = 1'b1;
        sb[lane].push_back('{due: cyc + LAT, proc: p, data: d});
        if (oob && err_from < 0) err_from = cyc + 1;
    endtask

    // Grant order: smallest rotational distance from the lane's pointer wins.
    task automatic cycle_step();
        int           bi, ba, bb, kbi, kba, kbb, key;
        bit           in_rst;
        logic [N-1:0] exp_rdy;
        @(negedge clk_in);
        exp_rdy = '0;
        bi = -1; ba = -1; bb = -1; kbi = 0; kba = 0; kbb = 0;
        in_rst = rst_in;
        for (int p = 0; p < N; p++) granted[p] = 1'b0;
        if (!in_rst) begin
            for (int p = 0; p < N; p++) begin
                if (!pv[p]) continue;
                key = (p - (pk[p] ? rr_d : rr_i) + N) % N;
                if (!pk[p]) begin
                    if (bi < 0 || key < kbi) begin bi = p; kbi = key; end
                end else if (ba < 0 || key < kba) begin
                    bb = ba; kbb = kba; ba = p; kba = key;
                end else if (bb < 0 || key < kbb) begin
                    bb = p; kbb = key;
                end
            end
            if (bi >= 0) push_grant(0, bi, exp_rdy);
            if (ba >= 0) push_grant(1, ba, exp_rdy);
            if (bb >= 0) push_grant(2, bb, exp_rdy);
            if (bi >= 0) rr_i = (bi + 1) % N;
            if (bb >= 0)      rr_d = (bb + 1) % N;
            else if (ba >= 0) rr_d = (ba + 1) % N;
        end
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk_in);
        #1;
        if (in_rst) begin
            for (int l = 0; l < 3; l++) sb[l].delete();
            rr_i = 0; rr_d = 0; err_from = -1;
        end
    endtask

    task automatic run_held();
        int budget;
        bit any;
        budget = 20;
        forever begin
            any = 1'b0;
            for (int p = 0; p < N; p++) any |= pv[p];
            if (!any) break;
            if (budget == 0) begin
                checks++; errors++;
                $display("FAIL run_held: requests still pending after 20 cycles (cycle %0d)", cyc);
                for (int p = 0; p < N; p++) pv[p] = 1'b0;
                break;
            end
            budget--;
            apply();
            cycle_step();
            for (int p = 0; p < N; p++) if (granted[p]) pv[p] = 1'b0;
        end
        apply();
        repeat (LAT + 2) cycle_step();
    endtask

    task automatic set_req(input int p, input bit k, input logic [31:0] a);
        pv[p] = 1'b1; pk[p] = k; pa[p] = a;
    endtask

    task automatic mon_lane(input int l, input logic v, input logic [PB-1:0] t, input logic [31:0] d);
        bit   due;
        exp_t e;
        due = sb[l].size() > 0 && sb[l][0].due == cyc;
        chk({lane_name[l], "_valid"}, v, due);
        if (due) begin
            e = sb[l].pop_front();
            chk({lane_name[l], "_tag"}, t, e.proc);
            chk({lane_name[l], "_data"}, d, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            if (mon_on) begin
                mon_lane(0, rowidx_valid_out, rowidx_proc_out, rowidx_out);
                mon_lane(1, data_valid_outa, data_proc_outa, data_outa);
                mon_lane(2, data_valid_outb, data_proc_outb, data_outb);
                chk("addr_err", addr_err, (err_from >= 0 && cyc >= err_from));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        for (int i = 0; i < ID; i++) begin idx_m[i]  = $urandom; dut.idx_mem[i]  = idx_m[i];  end
        for (int i = 0; i < DD; i++) begin data_m[i] = $urandom; dut.data_mem[i] = data_m[i]; end
        for (int p = 0; p < N; p++) begin pv[p] = 1'b0; pk[p] = 1'b0; pa[p] = '0; end
        apply();

        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        cycle_step();
        rst_in = 1'b0;
        mon_on = 1'b1;
        repeat (10) cycle_step();

        set_req(2, 1'b0, 32'd5);
        run_held();

        for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'(p * 10));
        run_held();

        set_req(1, 1'b0, 32'd7);
        set_req(3, 1'b1, 32'd100);
        run_held();

        set_req(0, 1'b1, 32'd16384);
        run_held();
        repeat (3) cycle_step();

        set_req(0, 1'b1, 32'd1);
        set_req(1, 1'b1, 32'd2);
        apply();
        cycle_step();
        pv[0] = 1'b0; pv[1] = 1'b0;
        rst_in = 1'b1;
        apply();
        cycle_step();
        rst_in = 1'b0;
        repeat (3) cycle_step();
        for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'(p + 40));
        run_held();

        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 60) begin
                    pv[p] = 1'b1;
                    pk[p] = 1'($urandom_range(0, 1));
                    r     = $urandom_range(0, 99);
                    if (r < 4)      pa[p] = 32'(pk[p] ? DD : ID) + $urandom_range(0, 1000);
                    else if (r < 6) pa[p] = 32'hFFFF_FF00 + $urandom_range(0, 255);
                    else            pa[p] = $urandom_range(0, (pk[p] ? DD : ID) - 1);
                end
            end
            rst_in = (c == 750);
            apply();
            cycle_step();
            for (int p = 0; p < N; p++) if (granted[p]) pv[p] = 1'b0;
        end
        rst_in = 1'b0;
        for (int p = 0; p < N; p++) pv[p] = 1'b0;
        apply();
        repeat (LAT + 3) cycle_step();
        chk("drain", sb[0].size() + sb[1].size() + sb[2].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
